// File: rtl/i2s_audio_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2s_audio_receiver: oversampled I2S deserialiser with valid/ready output.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module i2s_audio_receiver #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i2s_bclk,
  input  logic                  i2s_lrck,
  input  logic                  i2s_sdata,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic                  o_is_left,
  output logic [DATA_WIDTH-1:0] o_audio,
  output logic                  o_overrun
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [0:0] HUNT    = 1'b0;
  localparam logic [0:0] RECEIVE = 1'b1;
  localparam logic [DATA_WIDTH-1:0] MSB_ONE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic [SYNC_STAGES-1:0] sdata_sync;
  logic                   bclk_hist;

  logic [0:0]            state;
  logic                  lrck_last;
  logic                  lrck_primed;
  logic                  channel;
  logic [CW-1:0]         bit_count;
  logic [DATA_WIDTH-1:0] shreg;

  logic                  emit;
  logic                  emit_left;
  logic [DATA_WIDTH-1:0] emit_word;

  logic                  bclk_s;
  logic                  lrck_s;
  logic                  sdata_s;
  logic                  rise;
  logic                  boundary;
  logic                  bit_in_range;
  logic [DATA_WIDTH-1:0] bit_mask;
  logic [DATA_WIDTH-1:0] word_now;

  assign bclk_s  = bclk_sync[SYNC_STAGES-1];
  assign lrck_s  = lrck_sync[SYNC_STAGES-1];
  assign sdata_s = sdata_sync[SYNC_STAGES-1];
  assign rise    = bclk_s & ~bclk_hist;

  // lrck_last is meaningless until one rise has been seen after reset, so the
  // reset value cannot fake a boundary and start capture in the middle of a slot.
  assign boundary     = lrck_primed & (lrck_s != lrck_last);
  assign bit_in_range = (bit_count < CW'(DATA_WIDTH));
  // Mask shifts out to zero once bit_count saturates, so extra bits are ignored.
  assign bit_mask     = MSB_ONE >> bit_count;
  assign word_now     = sdata_s ? (shreg | bit_mask) : shreg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk_sync  <= '0;
      lrck_sync  <= '0;
      sdata_sync <= '0;
      bclk_hist  <= 1'b0;
    end else begin
      bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
      lrck_sync  <= {lrck_sync[SYNC_STAGES-2:0], i2s_lrck};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], i2s_sdata};
      bclk_hist  <= bclk_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HUNT;
      lrck_last   <= 1'b0;
      lrck_primed <= 1'b0;
      channel     <= 1'b0;
      bit_count   <= '0;
      shreg       <= '0;
      emit        <= 1'b0;
      emit_left   <= 1'b0;
      emit_word   <= '0;
    end else begin
      emit <= 1'b0;
      if (rise) begin
        lrck_last   <= lrck_s;
        lrck_primed <= 1'b1;
        case (state)
          HUNT: begin
            if (boundary) begin
              channel   <= lrck_s;
              bit_count <= '0;
              shreg     <= '0;
              state     <= RECEIVE;
            end
          end
          RECEIVE: begin
            if (boundary) begin
              emit      <= (bit_count != '0);
              emit_word <= word_now;
              emit_left <= ~channel;
              channel   <= lrck_s;
              bit_count <= '0;
              shreg     <= '0;
            end else begin
              shreg <= word_now;
              if (bit_in_range) begin
                bit_count <= bit_count + 1'b1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_valid   <= 1'b0;
      o_is_left <= 1'b0;
      o_audio   <= '0;
      o_overrun <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (emit) begin
        if (!o_valid || o_ready) begin
          o_valid   <= 1'b1;
          o_audio   <= emit_word;
          o_is_left <= emit_left;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_audio_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// Randomised I2S bench: a slot-level reference model predicts every output sample.
module tb_i2s_audio_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bclk = 1'b0;
  logic        lrck = 1'b0;
  logic        sdata = 1'b0;
  logic        o_ready = 1'b1;
  logic        o_valid;
  logic        o_is_left;
  logic [15:0] o_audio;
  logic        o_overrun;

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  int half = 4;
  bit rand_ready = 1'b0;

  int          s_len[$];
  logic [31:0] s_data[$];
  bit          s_ch[$];
  logic [16:0] exp_q[$];
  logic [16:0] mon_e;

  i2s_audio_receiver #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .i2s_bclk(bclk), .i2s_lrck(lrck), .i2s_sdata(sdata),
    .o_valid(o_valid), .o_ready(o_ready), .o_is_left(o_is_left), .o_audio(o_audio),
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Top 16 bits of a len-bit MSB-first word, zero padded when the slot is short.
  function automatic logic [15:0] model_word(input logic [31:0] d, input int len);
    if (len >= 16) return 16'(d >> (len - 16));
    return 16'(d << (16 - len));
  endfunction

  task automatic add_slot(input bit ch, input int len, input logic [31:0] data, input bit expect_out);
    logic [31:0] d;
    d = data;
    if (len < 32) d = d & ((32'h1 << len) - 32'h1);
    s_len.push_back(len);
    s_data.push_back(d);
    s_ch.push_back(ch);
    if (expect_out) exp_q.push_back({~ch, model_word(d, len)});
  endtask

  // The word-select line leads the data by one bit: lrck in a period names the
  // slot that owns the following bit.
  task automatic send_stream(input int rst_p);
    bit sd[$];
    bit cc[$];
    int n;
    for (int s = 0; s < s_len.size(); s++) begin
      for (int b = s_len[s] - 1; b >= 0; b--) begin
        sd.push_back(s_data[s][b]);
        cc.push_back(s_ch[s]);
      end
    end
    n = sd.size();
    @(posedge clk);
    #2;
    for (int p = 0; p < n; p++) begin
      bclk  = 1'b0;
      lrck  = (p + 1 < n) ? cc[p+1] : cc[p];
      sdata = sd[p];
      if (p == rst_p) begin
        reset = 1'b0;
        #1;
        check("midrst_valid", {31'b0, o_valid}, 32'd0);
        check("midrst_overrun", {31'b0, o_overrun}, 32'd0);
        #9;
        reset = 1'b1;
        #(half * 10 - 10);
      end else begin
        #(half * 10);
      end
      bclk = 1'b1;
      #(half * 10);
    end
    bclk = 1'b0;
  endtask

  task automatic do_reset();
    rand_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bclk  = 1'b0;
    lrck  = 1'b0;
    sdata = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, o_valid}, 32'd0);
    check("rst_is_left", {31'b0, o_is_left}, 32'd0);
    check("rst_audio", {16'b0, o_audio}, 32'd0);
    check("rst_overrun", {31'b0, o_overrun}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    ovr_cnt = 0;
  endtask

  task automatic finish_test(input string name, input int exp_ovr);
    repeat (40) @(posedge clk);
    check({name, "_drained"}, exp_q.size(), 32'd0);
    check({name, "_overruns"}, ovr_cnt, exp_ovr);
    exp_q.delete();
    s_len.delete();
    s_data.delete();
    s_ch.delete();
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (o_overrun) ovr_cnt++;
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_output", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("is_left", {31'b0, o_is_left}, {31'b0, mon_e[16]});
          check("audio", {16'b0, o_audio}, {16'b0, mon_e[15:0]});
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #2;
      o_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    // Standard 16-bit frames.
    do_reset();
    half = 4;
    o_ready = 1'b1;
    add_slot(1'b1, 5, 32'h15, 1'b0);
    for (int f = 0; f < 3; f++) begin
      add_slot(1'b0, 16, 32'h8001, 1'b1);
      add_slot(1'b1, 16, 32'h7FFE, 1'b1);
    end
    add_slot(1'b0, 3, 32'h5, 1'b0);
    send_stream(-1);
    finish_test("std16", 0);

    // 24-bit slots truncate to the top 16 bits.
    do_reset();
    add_slot(1'b1, 7, 32'h55, 1'b0);
    for (int f = 0; f < 2; f++) begin
      add_slot(1'b0, 24, 32'h123456, 1'b1);
      add_slot(1'b1, 24, 32'hFEDCBA, 1'b1);
    end
    add_slot(1'b0, 3, 32'h2, 1'b0);
    send_stream(-1);
    finish_test("slot24", 0);

    // 8-bit slots are zero padded.
    do_reset();
    half = 3;
    add_slot(1'b1, 4, 32'hF, 1'b0);
    for (int f = 0; f < 2; f++) begin
      add_slot(1'b0, 8, 32'hA5, 1'b1);
      add_slot(1'b1, 8, 32'h3C, 1'b1);
    end
    add_slot(1'b0, 3, 32'h7, 1'b0);
    send_stream(-1);
    finish_test("slot8", 0);

    // Backpressure: second completion is dropped, first is held.
    do_reset();
    half = 4;
    o_ready = 1'b0;
    add_slot(1'b1, 5, 32'h0A, 1'b0);
    add_slot(1'b0, 16, 32'h8001, 1'b1);
    add_slot(1'b1, 16, 32'h7FFE, 1'b0);
    add_slot(1'b0, 4, 32'h9, 1'b0);
    send_stream(-1);
    repeat (10) @(posedge clk);
    #1;
    check("bp_valid", {31'b0, o_valid}, 32'd1);
    check("bp_audio", {16'b0, o_audio}, 32'h8001);
    check("bp_is_left", {31'b0, o_is_left}, 32'd1);
    check("bp_overrun_count", ovr_cnt, 32'd1);
    o_ready = 1'b1;
    finish_test("backpressure", 1);

    // Stream begins mid-left-slot: the partial word never appears.
    do_reset();
    add_slot(1'b0, 9, 32'h1FF, 1'b0);
    add_slot(1'b1, 16, 32'h1357, 1'b1);
    add_slot(1'b0, 16, 32'h2468, 1'b1);
    add_slot(1'b1, 16, 32'hBEEF, 1'b1);
    add_slot(1'b0, 3, 32'h1, 1'b0);
    send_stream(-1);
    finish_test("midstart", 0);

    // Reset at bit 7 of a left slot, released inside that slot.
    do_reset();
    add_slot(1'b1, 5, 32'h11, 1'b0);
    add_slot(1'b0, 16, 32'h8001, 1'b1);
    add_slot(1'b1, 16, 32'h7FFE, 1'b1);
    add_slot(1'b0, 16, 32'h55AA, 1'b0);
    add_slot(1'b1, 16, 32'h0F0F, 1'b1);
    add_slot(1'b0, 16, 32'hC3C3, 1'b1);
    add_slot(1'b1, 3, 32'h3, 1'b0);
    send_stream(5 + 16 + 16 + 7);
    finish_test("midreset", 0);

    // Random slot lengths, data and downstream readiness.
    for (int t = 0; t < 6; t++) begin
      bit ch;
      int nslots;
      int len;
      do_reset();
      half = $urandom_range(3, 5);
      ch = 1'($urandom_range(0, 1));
      add_slot(ch, $urandom_range(2, 10), $urandom, 1'b0);
      nslots = $urandom_range(4, 6);
      for (int s = 0; s < nslots; s++) begin
        ch = ~ch;
        case ($urandom_range(0, 4))
          0: len = 8;
          1: len = 16;
          2: len = 24;
          3: len = 32;
          default: len = $urandom_range(8, 32);
        endcase
        add_slot(ch, len, $urandom, 1'b1);
      end
      add_slot(~ch, 3, $urandom, 1'b0);
      rand_ready = 1'b1;
      send_stream(-1);
      rand_ready = 1'b0;
      #3;
      o_ready = 1'b1;
      finish_test("random", 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_audio_receiver.md
Name: i2s_audio_receiver

Overview:
- Front-end of the audio level meter. Deserialises a standard I2S stream (BCLK, LRCK, SDATA) into 16-bit samples tagged left/right.
- Presents each sample on a valid/ready interface that feeds the meter's audio input port (i_valid/i_ready/i_is_left/i_audio).
- The I2S lines are asynchronous to clk. They are oversampled and edge-detected in the clk domain; no I2S-derived clock is used.

Parameters:
- data_width, 16, output sample width; the first data_width bits (MSB-first) of each slot are captured.
- sync_stages, 2, synchroniser flip-flops per I2S input (minimum 2).

Ports:
- clk  input  1  system clock; must be ≥ 4× BCLK, with each BCLK phase ≥ 2 clk periods.
- reset  input  1  asynchronous, active-low reset.
- i2s_bclk  input  1  I2S bit clock, asynchronous.
- i2s_lrck  input  1  I2S word select; 0 = left, 1 = right.
- i2s_sdata  input  1  I2S serial data, MSB first.
- o_valid  output  1  sample available.
- o_ready  input  1  downstream accepts the sample.
- o_is_left  output  1  1 when o_audio is a left-channel sample.
- o_audio  output  data_width  two's-complement sample, left-aligned.
- o_overrun  output  1  one-cycle pulse when a completed sample is dropped.

Behaviour:
- Reset (reset = 0, asynchronous):
  - o_valid = 0, o_is_left = 0, o_audio = 0, o_overrun = 0.
  - Synchronisers, shift register and bit counter cleared; FSM enters HUNT.
  - Reset mid-word discards the partial word and any pending output.
- Synchronisation:
  - bclk, lrck and sdata each pass through sync_stages flops.
  - One extra bclk history flop drives edge detection.
  - A BCLK rising edge event (rise) is a single-cycle pulse when synced bclk = 1 and history = 0.
  - All capture happens only on rise cycles, using synced lrck and sdata from that cycle.
- Slot boundary detection:
  - lrck_last holds the synced lrck captured at the previous rise.
  - Boundary = (lrck != lrck_last) at a rise.
  - I2S one-bit delay: the sdata bit at a boundary rise belongs to the ending slot. The next rise carries the MSB of the new slot.
- FSM HUNT:
  - Update lrck_last at each rise; shift nothing.
  - On the first boundary: channel <= lrck, bit_count <= 0, shift register <= 0, go to RECEIVE.
  - No output is produced from a slot entered mid-way.
- FSM RECEIVE, at each rise:
  - If bit_count < data_width: write sdata to bit (data_width-1-bit_count), then bit_count++.
  - bit_count saturates at data_width; further bits in a long slot (e.g. 24/32-bit) are ignored, which truncates to the top data_width bits.
  - The boundary-rise bit is written to the ending slot before it is evaluated.
- Emit (boundary rise in RECEIVE):
  - If bit_count ≥ 1, a completed word exists, equal to the shift register including the current bit.
  - Short slots are zero-padded at the LSBs.
  - If bit_count = 0 (LRCK glitch), nothing is emitted and o_overrun is not pulsed.
  - After evaluation: channel <= lrck, bit_count <= 0, shift register <= 0.
- Output register:
  - A completed word loads on the cycle after the boundary rise if o_valid = 0, or if o_valid & o_ready in that same cycle.
  - On load: o_valid = 1, o_audio = word, o_is_left = ~channel_of_ending_slot.
  - Otherwise the word is dropped, o_audio/o_is_left are held, and o_overrun pulses for 1 cycle.
  - o_valid stays high with o_audio/o_is_left stable until o_valid & o_ready.
  - o_valid clears the next cycle unless a load coincides.
- Latency: the BCLK edge at the pin reaches rise after sync_stages+1 clk cycles; o_valid rises one clk cycle later.
- LRCK polarity is fixed (0 = left). Slot length is free and need not be symmetric between left and right.

Test Plan:
- Standard frame, 16 bclk per slot, L = 0x8001, R = 0x7FFE, o_ready = 1 → output sequence (is_left = 1, 0x8001), (0, 0x7FFE), alternating each frame; no o_overrun.
- 24-bit slots, L = 0x123456, R = 0xFEDCBA → outputs 0x1234 and 0xFEDC.
- 8-bit slots, L = 0xA5, R = 0x3C → outputs 0xA500 and 0x3C00.
- Backpressure: o_ready = 0 across two slot completions → o_valid = 1 holding the first sample (0x8001, left); exactly one o_overrun pulse at the second completion. Raising o_ready then delivers 0x8001 once.
- Stream starts mid-left-slot → first output is the following right sample; the partial left word is never emitted.
- Reset asserted at bit 7 of a left slot, released mid-slot → o_valid = 0 immediately; FSM in HUNT; the next complete slot is output correctly with no overrun.
